vga_status_port: RTL and testbench
==================================

// Module: vga_status_port
// PURPOSE
//  CPU-readable memory-mapped responder carrying raster state from the VGA timing domain back to the CPU.
//  Runs in the CPU clk domain and decodes eight byte registers at BASE_ADDR..BASE_ADDR+7.
//  Crosses frame/line events from vga_clk with toggle synchronisers.
//  Exposes a sticky vblank flag, frame/line counters and an optional vblank interrupt.
// PARAMETERS
//  BASE_ADDR    16'h4008  byte base; selected when A[15:3]==BASE_ADDR[15:3] (BASE_ADDR[2:0] must be 0)
//  ACTIVE_ROWS  480       raster row at which vblank starts (frame event)
//  ID_VALUE     8'hA5     constant returned at offset 7
//  SYNC_STAGES  2         flops per synchroniser (>=2)
// PORTS
//  clk       in   1   CPU clock
//  n_rst     in   1   reset, asynchronous, active-low (resets both domains)
//  vga_clk   in   1   pixel clock
//  vga_row   in   10  raster row, vga_clk domain
//  vga_col   in   10  raster column, vga_clk domain
//  A         in   16  CPU address
//  rw        in   1   1 = CPU write, 0 = CPU read
//  d_out     in   8   CPU write data
//  d_in      out  8   read data to CPU; 0 when not selected
//  d_in_en   out  1   high when a read selects this block (bus mux enable)
//  irq       out  1   level interrupt, active-high
// BEHAVIOUR
//  vga domain: frame event when vga_row==ACTIVE_ROWS && vga_col==0; line event when vga_col==0.
//  Each event flips its own toggle flop. Toggles pass through SYNC_STAGES flops into clk.
//  An edge detect yields a 1-cycle pulse per event (fev, lev). clk must be >= 2x line rate.
//  Reads: d_in/d_in_en are combinational from registered state in the same cycle.
//  Read side effects apply at the clk edge that ends the read cycle.
//  Regs (offset): 0 STATUS RO | 1 FRAME_LO RO | 2 FRAME_HI RO (snapshot) | 3 LINE_LO RO
//   4 LINE_HI RO {6'b0,line[9:8]} | 5 CTRL RW {6'b0,freeze,irq_en} | 6 SCRATCH RW | 7 ID RO
//  STATUS = {irq_en,4'b0,overrun,in_vblank,vb_flag}.
//   in_vblank: synchronised level, set on fev, cleared on the first lev of line 0 (fev-relative line count wrap to 0 at next fev).
//  vb_flag: set on fev; cleared by a read of STATUS. Same cycle set+clear: set wins.
//  overrun: set when fev arrives with vb_flag already 1; cleared by a read of STATUS unless set in that same cycle.
//  frame: 16-bit, +1 per fev, wraps FFFF->0000.
//  line: 10-bit, zeroed on fev, +1 per lev, saturates at 1023.
//  freeze=1 holds frame and line; flags still update.
//  Reading FRAME_LO loads hi_snap<=frame[15:8]; FRAME_HI returns hi_snap (coherent 16-bit read).
//  Writes (rw=1) to offsets 5 and 6 update on that edge. Writes to RO offsets are ignored.
//  Write cycles never drive d_in_en.
//  irq = vb_flag & irq_en (registered inputs, no extra latency).
//  Reset: all flops 0 (toggles, sync chains, flags, counters, hi_snap, CTRL, SCRATCH).
//  Reset values: d_in=0, d_in_en=0, irq=0.
//  Reset mid-frame: first post-reset toggle change yields exactly one pulse. No spurious events.
// CONFIGURATION
//  VGA_STATUS_IRQ_EN defined: CTRL[0] is writable and irq is driven as above.
//  Not defined: CTRL[0] and STATUS[7] read 0, writes to them are ignored, irq tied to 0.
//  All other behaviour is identical with and without the macro.
// STRUCTURE
//  vga_status_pkg: register offset localparams, STATUS/CTRL bit indices, default ID_VALUE.
//  Sub-module toggle_sync: SYNC_STAGES flop chain plus edge-detect pulse.
//  Instantiated twice (frame, line).
// TESTING
//  Raster run to row 480: exactly one fev. STATUS reads 8'h03. Second read reads 8'h02.
//  Two fevs with no STATUS read: overrun=1, STATUS=8'h07. After the read, overrun=0 and vb_flag=0.
//  frame preloaded 16'h00FF: read FRAME_LO=FF, then fev, then read FRAME_HI=00 (snapshot); next LO reads 00.
//  Write CTRL=8'h01, then fev: irq=1. Read STATUS: irq=0. With macro undefined, irq stays 0.
//  freeze=1 across 3 fevs: frame unchanged; vb_flag still set.
//  Write 8'h5A to offset 6: reads 5A. Write to offset 7: ID still A5.
//  Unselected address: d_in=0, d_in_en=0.
//  Assert n_rst mid-line: all outputs 0; next fev counted once.
//  STATUS read coincident with fev: returns old value, vb_flag=1 afterwards.

Source files
------------

// File: rtl/vga_status_pkg.sv
// Shared constants for the VGA raster status port: register map and bit positions.
// Register offsets are byte offsets from the block base address.
package vga_status_pkg;

  localparam logic [2:0] OFF_STATUS   = 3'd0;
  localparam logic [2:0] OFF_FRAME_LO = 3'd1;
  localparam logic [2:0] OFF_FRAME_HI = 3'd2;
  localparam logic [2:0] OFF_LINE_LO  = 3'd3;
  localparam logic [2:0] OFF_LINE_HI  = 3'd4;
  localparam logic [2:0] OFF_CTRL     = 3'd5;
  localparam logic [2:0] OFF_SCRATCH  = 3'd6;
  localparam logic [2:0] OFF_ID       = 3'd7;

  localparam int ST_VB     = 0;
  localparam int ST_INVB   = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_IRQEN  = 7;

  localparam int CTRL_IRQEN  = 0;
  localparam int CTRL_FREEZE = 1;

  localparam logic [7:0] ID_DEFAULT = 8'hA5;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_status_port_toggle_sync.sv
// Toggle synchroniser: SYNC_STAGES flop chain into the destination clock,
// followed by an edge detect that emits one pulse per source toggle.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tgl_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/vga_status_port.sv
// CPU-side memory-mapped status port for VGA raster state (frame/line/vblank).
// Define VGA_STATUS_IRQ_EN to enable the writable irq enable and the irq output.
module vga_status_port
  import vga_status_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h4008,
  parameter int          ACTIVE_ROWS = 480,
  parameter logic [7:0]  ID_VALUE    = ID_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        vga_clk,
  input  logic [9:0]  vga_row,
  input  logic [9:0]  vga_col,
  input  logic [15:0] A,
  input  logic        rw,
  input  logic [7:0]  d_out,
  output logic [7:0]  d_in,
  output logic        d_in_en,
  output logic        irq
);

  logic frame_tgl_q;
  logic line_tgl_q;
  logic vblank_q;
  logic fev_v;
  logic lev_v;

  assign lev_v = (vga_col == '0);
  assign fev_v = lev_v && (vga_row == 10'(ACTIVE_ROWS));

  always_ff @(posedge vga_clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_tgl_q <= 1'b0;
      line_tgl_q  <= 1'b0;
      vblank_q    <= 1'b0;
    end else begin
      if (fev_v) frame_tgl_q <= ~frame_tgl_q;
      if (lev_v) line_tgl_q  <= ~line_tgl_q;
      if (fev_v)
        vblank_q <= 1'b1;
      else if (lev_v && vga_row == '0)
        vblank_q <= 1'b0;
    end
  end

  logic fev;
  logic lev;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fsync (
    .clk(clk), .n_rst(n_rst), .tgl_i(frame_tgl_q), .pulse_o(fev)
  );

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lsync (
    .clk(clk), .n_rst(n_rst), .tgl_i(line_tgl_q), .pulse_o(lev)
  );

  // Same depth as the toggle chains so the level lands with fev.
  logic [SYNC_STAGES-1:0] vb_sync_q;
  logic                   in_vblank;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) vb_sync_q <= '0;
    else        vb_sync_q <= {vb_sync_q[SYNC_STAGES-2:0], vblank_q};
  end

  assign in_vblank = vb_sync_q[SYNC_STAGES-1];

  logic       sel;
  logic       rd;
  logic       wr;
  logic [2:0] off;

  assign sel = (A[15:3] == BASE_ADDR[15:3]);
  assign rd  = sel && !rw;
  assign wr  = sel && rw;
  assign off = A[2:0];

  logic        vb_flag_q, vb_flag_d;
  logic        ovr_q, ovr_d;
  logic [15:0] frame_q, frame_d;
  logic [9:0]  line_q, line_d;
  logic [7:0]  hi_snap_q, hi_snap_d;
  logic        freeze_q, freeze_d;
  logic [7:0]  scratch_q, scratch_d;
  logic        irq_en;

  always_comb begin
    vb_flag_d = vb_flag_q;
    ovr_d     = ovr_q;
    frame_d   = frame_q;
    line_d    = line_q;
    hi_snap_d = hi_snap_q;
    freeze_d  = freeze_q;
    scratch_d = scratch_q;
    if (rd && off == OFF_STATUS) begin
      vb_flag_d = 1'b0;
      ovr_d     = 1'b0;
    end
    if (fev) begin
      vb_flag_d = 1'b1;
      if (vb_flag_q) ovr_d = 1'b1;
    end
    if (!freeze_q) begin
      if (fev) begin
        frame_d = frame_q + 16'd1;
        line_d  = '0;
      end else if (lev) begin
        line_d = sat_inc10(line_q);
      end
    end
    if (rd && off == OFF_FRAME_LO) hi_snap_d = frame_q[15:8];
    if (wr && off == OFF_CTRL)     freeze_d  = d_out[CTRL_FREEZE];
    if (wr && off == OFF_SCRATCH)  scratch_d = d_out;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vb_flag_q <= 1'b0;
      ovr_q     <= 1'b0;
      frame_q   <= '0;
      line_q    <= '0;
      hi_snap_q <= '0;
      freeze_q  <= 1'b0;
      scratch_q <= '0;
    end else begin
      vb_flag_q <= vb_flag_d;
      ovr_q     <= ovr_d;
      frame_q   <= frame_d;
      line_q    <= line_d;
      hi_snap_q <= hi_snap_d;
      freeze_q  <= freeze_d;
      scratch_q <= scratch_d;
    end
  end

`ifdef VGA_STATUS_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      irq_en_q <= 1'b0;
    else if (wr && off == OFF_CTRL)
      irq_en_q <= d_out[CTRL_IRQEN];
  end

  assign irq_en = irq_en_q;
  assign irq    = vb_flag_q & irq_en_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  logic [7:0] status;
  logic [7:0] ctrl;
  logic [7:0] rdata;

  always_comb begin
    status            = '0;
    status[ST_VB]     = vb_flag_q;
    status[ST_INVB]   = in_vblank;
    status[ST_OVR]    = ovr_q;
    status[ST_IRQEN]  = irq_en;
    ctrl              = '0;
    ctrl[CTRL_IRQEN]  = irq_en;
    ctrl[CTRL_FREEZE] = freeze_q;
  end

  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_STATUS:   rdata = status;
      OFF_FRAME_LO: rdata = frame_q[7:0];
      OFF_FRAME_HI: rdata = hi_snap_q;
      OFF_LINE_LO:  rdata = line_q[7:0];
      OFF_LINE_HI:  rdata = {6'b0, line_q[9:8]};
      OFF_CTRL:     rdata = ctrl;
      OFF_SCRATCH:  rdata = scratch_q;
      OFF_ID:       rdata = ID_VALUE;
      default:      rdata = '0;
    endcase
  end

  assign d_in    = rd ? rdata : 8'h00;
  assign d_in_en = rd;

endmodule

// File: tb/tb_vga_status_port.sv
// Directed bench for vga_status_port: raster events, register map, reset.
// Expectations follow the default build unless VGA_STATUS_IRQ_EN is defined.
module tb_vga_status_port;

  localparam logic [15:0] BASE = 16'h4008;
`ifdef VGA_STATUS_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        vga_clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [9:0]  vga_row = '0;
  logic [9:0]  vga_col = 10'd1;
  logic [15:0] A = '0;
  logic        rw = 1'b0;
  logic [7:0]  d_out = '0;
  logic [7:0]  d_in;
  logic        d_in_en;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always #7 vga_clk = ~vga_clk;

  vga_status_port dut (
    .clk(clk), .n_rst(n_rst), .vga_clk(vga_clk),
    .vga_row(vga_row), .vga_col(vga_col),
    .A(A), .rw(rw), .d_out(d_out),
    .d_in(d_in), .d_in_en(d_in_en), .irq(irq)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rdchk(input string tag, input logic [2:0] off,
                       input logic [7:0] exp);
    @(negedge clk);
    A  = BASE + 16'(off);
    rw = 1'b0;
    #1;
    check(tag, 16'(d_in), 16'(exp));
    check({tag, "_en"}, 16'(d_in_en), 16'h1);
    @(negedge clk);
    A = '0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    @(negedge clk);
    A     = BASE + 16'(off);
    rw    = 1'b1;
    d_out = d;
    #1;
    check("wr_no_en", 16'(d_in_en), 16'h0);
    @(negedge clk);
    A  = '0;
    rw = 1'b0;
  endtask

  task automatic vline(input logic [9:0] r);
    @(negedge vga_clk);
    vga_row = r;
    vga_col = '0;
    @(negedge vga_clk);
    vga_col = 10'd1;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int  k;
    logic hit;

    repeat (3) @(negedge clk);
    #1;
    check("rst_d_in", 16'(d_in), 16'h0);
    check("rst_en", 16'(d_in_en), 16'h0);
    check("rst_irq", 16'(irq), 16'h0);
    @(negedge clk);
    n_rst = 1'b1;
    settle();

    rdchk("id", 3'd7, 8'hA5);
    rdchk("st_rst", 3'd0, 8'h00);
    rdchk("frame_rst", 3'd1, 8'h00);

    for (int r = 0; r <= 480; r++) vline(10'(r));
    settle();
    rdchk("st_fev", 3'd0, 8'h03);
    rdchk("st_again", 3'd0, 8'h02);
    rdchk("frame1", 3'd1, 8'h01);
    rdchk("line0", 3'd3, 8'h00);
    vline(10'd481);
    vline(10'd482);
    vline(10'd483);
    settle();
    rdchk("line3", 3'd3, 8'h03);
    rdchk("line_hi", 3'd4, 8'h00);
    rdchk("st_hold", 3'd0, 8'h02);

    vline(10'd480);
    settle();
    vline(10'd480);
    settle();
    rdchk("st_ovr", 3'd0, 8'h07);
    rdchk("st_ovr_clr", 3'd0, 8'h02);

    wr(3'd5, 8'h01);
    rdchk("ctrl_irq", 3'd5, IRQ ? 8'h01 : 8'h00);
    check("irq_pre", 16'(irq), 16'h0);
    vline(10'd480);
    settle();
    check("irq_set", 16'(irq), 16'(IRQ));
    rdchk("st_irq", 3'd0, IRQ ? 8'h83 : 8'h03);
    check("irq_clr", 16'(irq), 16'h0);
    wr(3'd5, 8'h00);

    vline(10'd481);
    settle();
    wr(3'd5, 8'h02);
    rdchk("ctrl_frz", 3'd5, 8'h02);
    rdchk("fr_pre", 3'd1, 8'h04);
    vline(10'd480);
    vline(10'd480);
    vline(10'd480);
    settle();
    rdchk("st_frz", 3'd0, 8'h07);
    rdchk("fr_frz", 3'd1, 8'h04);
    rdchk("ln_frz", 3'd3, 8'h01);
    wr(3'd5, 8'h00);

    for (int i = 0; i < 251; i++) vline(10'd480);
    settle();
    rdchk("fr_ff", 3'd1, 8'hFF);
    vline(10'd480);
    settle();
    rdchk("fr_snap", 3'd2, 8'h00);
    rdchk("fr_lo100", 3'd1, 8'h00);
    rdchk("fr_hi100", 3'd2, 8'h01);
    rdchk("st_many", 3'd0, 8'h07);
    rdchk("st_many2", 3'd0, 8'h02);

    wr(3'd6, 8'h5A);
    rdchk("scratch", 3'd6, 8'h5A);
    wr(3'd7, 8'h33);
    rdchk("id_ro", 3'd7, 8'hA5);
    wr(3'd0, 8'hFF);
    rdchk("st_ro", 3'd0, 8'h02);

    @(negedge clk);
    A  = 16'h4010;
    rw = 1'b0;
    #1;
    check("unsel_hi", 16'(d_in), 16'h0);
    check("unsel_hi_en", 16'(d_in_en), 16'h0);
    A = 16'h4007;
    #1;
    check("unsel_lo", 16'(d_in), 16'h0);
    check("unsel_lo_en", 16'(d_in_en), 16'h0);
    @(negedge clk);
    A = '0;

    for (int i = 0; i < 1030; i++) vline(10'd481);
    settle();
    rdchk("ln_sat_lo", 3'd3, 8'hFF);
    rdchk("ln_sat_hi", 3'd4, 8'h03);

    @(negedge vga_clk);
    vga_row = 10'd480;
    vga_col = '0;
    @(negedge vga_clk);
    vga_col = 10'd1;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < 40) begin
      @(negedge clk);
      k++;
      if (dut.fev === 1'b1) hit = 1'b1;
    end
    check("fev_seen", 16'(hit), 16'h1);
    A  = BASE;
    rw = 1'b0;
    #1;
    check("coinc_old", 16'(d_in), 16'h02);
    @(negedge clk);
    A = '0;
    settle();
    rdchk("coinc_after", 3'd0, 8'h03);
    rdchk("coinc_clr", 3'd0, 8'h02);

    @(negedge vga_clk);
    vga_row = 10'd100;
    vga_col = '0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mrst_d_in", 16'(d_in), 16'h0);
    check("mrst_en", 16'(d_in_en), 16'h0);
    check("mrst_irq", 16'(irq), 16'h0);
    repeat (2) @(negedge clk);
    vga_col = 10'd1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    settle();
    rdchk("mrst_st", 3'd0, 8'h00);
    rdchk("mrst_fr", 3'd1, 8'h00);
    rdchk("mrst_ln", 3'd3, 8'h00);
    rdchk("mrst_scr", 3'd6, 8'h00);
    vline(10'd480);
    settle();
    rdchk("mrst_fr1", 3'd1, 8'h01);
    rdchk("mrst_st1", 3'd0, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
